// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: one bit per cycle, width iterations + 1 finalize cycle.
// Signed operations run on magnitudes; the sign correction is applied in the finalize cycle.
module mcycle_unit #(
  parameter int width = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic [1:0]       MCycleOp,
  input  logic [width-1:0] Operand1,
  input  logic [width-1:0] Operand2,
  output logic [width-1:0] Result1,
  output logic [width-1:0] Result2,
  output logic             Busy
);

  localparam int CW = $clog2(width + 1);
  localparam logic [width-1:0] MOST_NEG = {1'b1, {(width-1){1'b0}}};

  typedef enum logic {IDLE, COMPUTING} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [1:0]       op;
  logic [width-1:0] opa, opb;
  logic [width-1:0] mag_b;
  logic [width-1:0] hi, lo;
  logic             neg_q, neg_r;
  logic             last;

  // launch-time magnitudes and signs
  logic             sgn_in, s1, s2;
  logic [width-1:0] m1, m2;

  // iteration datapath
  logic [width:0]   mul_sum;
  logic [width:0]   div_trial;

  // finalize datapath
  logic [2*width-1:0] prod, prod_s;
  logic [width-1:0]   quo_s, rem_s;
  logic               div_zero, div_ovf;

  assign last = (cnt == CW'(width));

  always_comb begin
    sgn_in = ~MCycleOp[0];
    s1     = sgn_in & Operand1[width-1];
    s2     = sgn_in & Operand2[width-1];
    m1     = s1 ? (~Operand1 + 1'b1) : Operand1;
    m2     = s2 ? (~Operand2 + 1'b1) : Operand2;
  end

  // Multiply and divide share the {hi, lo} pair: lo holds multiplier/quotient, hi the
  // upper accumulator/partial remainder.
  always_comb begin
    mul_sum   = {1'b0, hi} + {1'b0, (lo[0] ? mag_b : '0)};
    div_trial = {hi, lo[width-1]} - {1'b0, mag_b};
  end

  always_comb begin
    prod     = {hi, lo};
    prod_s   = neg_q ? (~prod + 1'b1) : prod;
    quo_s    = neg_q ? (~lo + 1'b1) : lo;
    rem_s    = neg_r ? (~hi + 1'b1) : hi;
    div_zero = (opb == '0);
    div_ovf  = (op == 2'b10) && (opa == MOST_NEG) && (opb == '1);
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (Start) state_nxt = COMPUTING;
      COMPUTING: if (last)  state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    Busy = (state == COMPUTING);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt     <= '0;
      op      <= '0;
      opa     <= '0;
      opb     <= '0;
      mag_b   <= '0;
      hi      <= '0;
      lo      <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            cnt   <= '0;
            op    <= MCycleOp;
            opa   <= Operand1;
            opb   <= Operand2;
            hi    <= '0;
            neg_q <= s1 ^ s2;
            neg_r <= s1;
            if (MCycleOp[1]) begin
              lo    <= m1;
              mag_b <= m2;
            end else begin
              lo    <= m2;
              mag_b <= m1;
            end
          end
        end
        COMPUTING: begin
          if (!last) begin
            cnt <= cnt + 1'b1;
            if (!op[1]) begin
              hi <= mul_sum[width:1];
              lo <= {mul_sum[0], lo[width-1:1]};
            end else if (!div_trial[width]) begin
              hi <= div_trial[width-1:0];
              lo <= {lo[width-2:0], 1'b1};
            end else begin
              hi <= {hi[width-2:0], lo[width-1]};
              lo <= {lo[width-2:0], 1'b0};
            end
          end else begin
            if (!op[1]) begin
              Result1 <= prod_s[width-1:0];
              Result2 <= prod_s[2*width-1:width];
            end else if (div_zero) begin
              Result1 <= '1;
              Result2 <= opa;
            end else if (div_ovf) begin
              Result1 <= MOST_NEG;
              Result2 <= '0;
            end else begin
              Result1 <= quo_s;
              Result2 <= rem_s;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcycle_unit.sv
// Self-checking bench for mcycle_unit: directed cases, randomized ops against an
// arithmetic reference model, reset abort, result hold and back-to-back Start.
module tb_mcycle_unit;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         Start = 1'b0;
  logic [1:0]   MCycleOp = '0;
  logic [W-1:0] Operand1 = '0;
  logic [W-1:0] Operand2 = '0;
  logic [W-1:0] Result1, Result2;
  logic         Busy;

  int nchk = 0;
  int nfail = 0;

  mcycle_unit #(.width(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
    .Operand1(Operand1), .Operand2(Operand2),
    .Result1(Result1), .Result2(Result2), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  // Reference model from plain integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r1, output logic [W-1:0] r2);
    longint sa, sb, ua, ub, p, q, r;
    logic [2*W-1:0] pw;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    if (!op[1]) begin
      p  = op[0] ? ua * ub : sa * sb;
      pw = p[2*W-1:0];
      r1 = pw[W-1:0];
      r2 = pw[2*W-1:W];
    end else if (b == 0) begin
      r1 = '1;
      r2 = a;
    end else if (!op[0] && sa == -(longint'(1) << (W-1)) && sb == -1) begin
      r1 = {1'b1, {(W-1){1'b0}}};
      r2 = '0;
    end else begin
      q  = op[0] ? ua / ub : sa / sb;
      r  = op[0] ? ua % ub : sa % sb;
      r1 = q[W-1:0];
      r2 = r[W-1:0];
    end
  endfunction

  // Launch one op, scramble inputs while busy, check latency and results.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input string name);
    logic [W-1:0] e1, e2;
    int cycles;
    model(op, a, b, e1, e2);
    @(negedge CLK);
    Start = 1'b1; MCycleOp = op; Operand1 = a; Operand2 = b;
    @(negedge CLK);
    Start = 1'b0;
    MCycleOp = 2'($urandom); Operand1 = W'($urandom); Operand2 = W'($urandom);
    cycles = 0;
    while (Busy && cycles < 20) begin
      cycles++;
      @(negedge CLK);
    end
    nchk++;
    if (cycles !== W + 1) begin
      nfail++;
      $display("FAIL %s busy_cycles got=%0d exp=%0d", name, cycles, W + 1);
    end
    nchk++;
    if (Result1 !== e1 || Result2 !== e2) begin
      nfail++;
      $display("FAIL %s op=%b a=%b b=%b got r1=%b r2=%b exp r1=%b r2=%b",
               name, op, a, b, Result1, Result2, e1, e2);
    end
  endtask

  task automatic test_reset;
    @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    nchk++;
    if (Busy !== 1'b0 || Result1 !== '0 || Result2 !== '0) begin
      nfail++;
      $display("FAIL reset got busy=%b r1=%b r2=%b exp busy=0 r1=0000 r2=0000", Busy, Result1, Result2);
    end
  endtask

  task automatic test_mul;
    run_op(2'b00, 4'b1111, 4'b1111, "smul_m1xm1");
    run_op(2'b00, 4'b1101, 4'b0010, "smul_m3x2");
    run_op(2'b01, 4'b0010, 4'b0110, "umul_2x6");
    run_op(2'b01, 4'b1111, 4'b1111, "umul_15x15");
    run_op(2'b00, 4'b1000, 4'b1000, "smul_mneg_sq");
  endtask

  task automatic test_div;
    run_op(2'b10, 4'b1100, 4'b0011, "sdiv_a");
    run_op(2'b10, 4'b1010, 4'b1100, "sdiv_b");
    run_op(2'b10, 4'b0011, 4'b1110, "sdiv_c");
    run_op(2'b10, 4'b1100, 4'b1100, "sdiv_d");
    run_op(2'b10, 4'b0000, 4'b1110, "sdiv_e");
    run_op(2'b11, 4'b1000, 4'b0100, "udiv_a");
    run_op(2'b11, 4'b0100, 4'b1000, "udiv_b");
    run_op(2'b11, 4'b0000, 4'b0101, "udiv_c");
    run_op(2'b11, 4'b1111, 4'b0001, "udiv_d");
  endtask

  task automatic test_corner;
    run_op(2'b11, 4'b0111, 4'b0000, "udiv_zero");
    run_op(2'b10, 4'b1010, 4'b0000, "sdiv_zero");
    run_op(2'b10, 4'b1000, 4'b1111, "sdiv_ovf");
    run_op(2'b10, 4'b1000, 4'b0001, "sdiv_mneg_by_1");
  endtask

  task automatic test_random;
    for (int i = 0; i < 60; i++)
      run_op(2'($urandom), W'($urandom), W'($urandom), "random");
  endtask

  task automatic test_hold;
    logic [W-1:0] h1, h2;
    logic [W-1:0] e1, e2;
    run_op(2'b00, 4'b0111, 4'b0011, "hold_setup");
    model(2'b00, 4'b0111, 4'b0011, e1, e2);
    h1 = Result1; h2 = Result2;
    for (int i = 0; i < 4; i++) begin
      Operand1 = W'($urandom); Operand2 = W'($urandom); MCycleOp = 2'($urandom);
      @(negedge CLK);
    end
    nchk++;
    if (Result1 !== e1 || Result2 !== e2 || Busy !== 1'b0) begin
      nfail++;
      $display("FAIL hold got r1=%b r2=%b busy=%b exp r1=%b r2=%b busy=0", Result1, Result2, Busy, e1, e2);
    end
  endtask

  task automatic test_reset_abort;
    run_op(2'b01, 4'b1111, 4'b0011, "abort_setup");
    @(negedge CLK);
    Start = 1'b1; MCycleOp = 2'b11; Operand1 = 4'b1110; Operand2 = 4'b0011;
    @(negedge CLK);
    Start = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    nchk++;
    if (Busy !== 1'b0 || Result1 !== '0 || Result2 !== '0) begin
      nfail++;
      $display("FAIL reset_abort got busy=%b r1=%b r2=%b exp busy=0 r1=0000 r2=0000", Busy, Result1, Result2);
    end
    RESET = 1'b0;
    @(negedge CLK);
    nchk++;
    if (Busy !== 1'b0) begin
      nfail++;
      $display("FAIL reset_abort_idle got busy=%b exp 0", Busy);
    end
  endtask

  // Start held high: each op's operands are presented in the single idle cycle.
  task automatic test_back_to_back;
    logic [1:0]   ops[$];
    logic [W-1:0] as[$], bs[$];
    logic [W-1:0] e1, e2;
    int cycles;
    for (int i = 0; i < 6; i++) begin
      ops.push_back(2'($urandom)); as.push_back(W'($urandom)); bs.push_back(W'($urandom));
    end
    @(negedge CLK);
    Start = 1'b1; MCycleOp = ops[0]; Operand1 = as[0]; Operand2 = bs[0];
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      nchk++;
      if (Busy !== 1'b1) begin
        nfail++;
        $display("FAIL b2b_gap op%0d got busy=%b exp 1", i, Busy);
      end
      cycles = 0;
      while (Busy && cycles < 20) begin
        cycles++;
        @(negedge CLK);
      end
      model(ops[i], as[i], bs[i], e1, e2);
      nchk++;
      if (cycles !== W + 1 || Result1 !== e1 || Result2 !== e2) begin
        nfail++;
        $display("FAIL b2b op%0d cycles=%0d r1=%b r2=%b exp cycles=%0d r1=%b r2=%b",
                 i, cycles, Result1, Result2, W + 1, e1, e2);
      end
      if (i < 5) begin
        MCycleOp = ops[i+1]; Operand1 = as[i+1]; Operand2 = bs[i+1];
      end else begin
        Start = 1'b0;
      end
    end
    @(negedge CLK);
    nchk++;
    if (Busy !== 1'b0) begin
      nfail++;
      $display("FAIL b2b_stop got busy=%b exp 0", Busy);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_corner();
    test_random();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
